// File: rtl/chart_pkg.sv
// Shared types and defaults for chart selection; FIRST/NUM defaults also feed the
// game core's chart ROM select.
package chart_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DEF_FIRST_CHART = 1;
  localparam int unsigned DEF_NUM_CHARTS = 3;

  typedef enum logic [1:0] {
    StBrowse,
    StConfirm,
    StStart,
    StLocked
  } chart_state_e;

  // One step of the chart digit; at a limit either wraps to the other end or holds.
  function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] d,
                                                    input logic               up,
                                                    input logic [DIGIT_W-1:0] lo,
                                                    input logic [DIGIT_W-1:0] hi,
                                                    input logic               wrap);
    logic [DIGIT_W-1:0] r;
    if (up) begin
      if (d == hi) r = wrap ? lo : hi;
      else         r = d + DIGIT_W'(1);
    end else begin
      if (d == lo) r = wrap ? hi : lo;
      else         r = d - DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/chart_select_ctrl_if.sv
// Button/frame inputs and overlay/game-core outputs of the chart selection screen.
interface chart_select_ctrl_if;
  import chart_pkg::*;

  logic               frame_tick;
  logic               btn_next;
  logic               btn_prev;
  logic               btn_confirm;
  logic               game_done;
  logic [DIGIT_W-1:0] chart_digit;
  logic               label_on;
  logic               chart_start;
  logic               chart_locked;

  modport master (
    output frame_tick, btn_next, btn_prev, btn_confirm, game_done,
    input  chart_digit, label_on, chart_start, chart_locked
  );

  modport slave (
    input  frame_tick, btn_next, btn_prev, btn_confirm, game_done,
    output chart_digit, label_on, chart_start, chart_locked
  );

endinterface

// File: rtl/btn_edge_detect.sv
// Rising-edge press detector; history resets to 1 so a button held through reset
// release never registers a press.
module btn_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic hist_q, hist_d;

  always_comb begin
    hist_d  = btn_i;
    press_o = btn_i & ~hist_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= 1'b1;
    else         hist_q <= hist_d;
  end

endmodule

// File: rtl/chart_select_ctrl.sv
// Chart selection sequencer: browse digit, blink label on confirm, pulse start, lock
// until game_done. Define CHART_SEL_WRAP_EN to wrap the digit instead of saturating.
module chart_select_ctrl
  import chart_pkg::*;
#(
  parameter int unsigned FIRST_CHART    = DEF_FIRST_CHART,
  parameter int unsigned NUM_CHARTS     = DEF_NUM_CHARTS,
  parameter int unsigned BLINK_FRAMES   = 8,
  parameter int unsigned CONFIRM_BLINKS = 3
) (
  input logic                clk,
  input logic                resetn,
  chart_select_ctrl_if.slave bus
);

  localparam int unsigned FrameW  = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned ToggleW = $clog2(2 * CONFIRM_BLINKS + 1);

  localparam logic [DIGIT_W-1:0] FirstDigit = DIGIT_W'(FIRST_CHART);
  localparam logic [DIGIT_W-1:0] TopDigit   = DIGIT_W'(FIRST_CHART + NUM_CHARTS - 1);
  localparam logic [FrameW-1:0]  FrameLast  = FrameW'(BLINK_FRAMES - 1);
  // The entry toggle is not counted, so the last counted toggle has index 2*N-2.
  localparam logic [ToggleW-1:0] ToggleLast = ToggleW'(2 * CONFIRM_BLINKS - 2);

`ifdef CHART_SEL_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  chart_state_e       state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               label_q, label_d;
  logic               start_q, start_d;
  logic               locked_q, locked_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [ToggleW-1:0] tog_q, tog_d;

  logic press_next, press_prev, press_confirm;

  btn_edge_detect u_edge_next (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .btn_i   (bus.btn_next),
    .press_o (press_next)
  );

  btn_edge_detect u_edge_prev (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .btn_i   (bus.btn_prev),
    .press_o (press_prev)
  );

  btn_edge_detect u_edge_confirm (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .btn_i   (bus.btn_confirm),
    .press_o (press_confirm)
  );

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    label_d  = label_q;
    start_d  = 1'b0;
    locked_d = locked_q;
    frame_d  = frame_q;
    tog_d    = tog_q;

    unique case (state_q)
      StBrowse: begin
        label_d = 1'b1;
        if (press_confirm) begin
          state_d = StConfirm;
          label_d = 1'b0;
          frame_d = '0;
          tog_d   = '0;
        end else if (press_next ^ press_prev) begin
          digit_d = step_digit(digit_q, press_next, FirstDigit, TopDigit, WrapEn);
        end
      end
      StConfirm: begin
        if (bus.frame_tick) begin
          if (frame_q == FrameLast) begin
            frame_d = '0;
            label_d = ~label_q;
            tog_d   = tog_q + ToggleW'(1);
            if (tog_q == ToggleLast) begin
              state_d  = StStart;
              start_d  = 1'b1;
              locked_d = 1'b1;
            end
          end else begin
            frame_d = frame_q + FrameW'(1);
          end
        end
      end
      StStart: begin
        state_d  = StLocked;
        locked_d = 1'b1;
        label_d  = 1'b1;
      end
      StLocked: begin
        label_d  = 1'b1;
        locked_d = 1'b1;
        if (bus.game_done) begin
          state_d  = StBrowse;
          locked_d = 1'b0;
        end
      end
      default: state_d = StBrowse;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StBrowse;
      digit_q  <= FirstDigit;
      label_q  <= 1'b1;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
      frame_q  <= '0;
      tog_q    <= '0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      label_q  <= label_d;
      start_q  <= start_d;
      locked_q <= locked_d;
      frame_q  <= frame_d;
      tog_q    <= tog_d;
    end
  end

  assign bus.chart_digit  = digit_q;
  assign bus.label_on     = label_q;
  assign bus.chart_start  = start_q;
  assign bus.chart_locked = locked_q;

endmodule

// File: tb/tb_chart_select_ctrl.sv
// Directed bench for chart_select_ctrl with default parameters (1..3, 8 frames, 3 blinks).
module tb_chart_select_ctrl;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  chart_select_ctrl_if bus_if ();

  chart_select_ctrl #(
    .FIRST_CHART    (1),
    .NUM_CHARTS     (3),
    .BLINK_FRAMES   (8),
    .CONFIRM_BLINKS (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press one button (0 next, 1 prev, 2 confirm) and check the digit one edge later.
  task automatic press(input int which, input logic [3:0] exp, input string tag);
    if (which == 0) bus_if.btn_next = 1'b1;
    if (which == 1) bus_if.btn_prev = 1'b1;
    if (which == 2) bus_if.btn_confirm = 1'b1;
    tick();
    chk(tag, 32'(bus_if.chart_digit), 32'(exp));
    bus_if.btn_next    = 1'b0;
    bus_if.btn_prev    = 1'b0;
    bus_if.btn_confirm = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digit"}, 32'(bus_if.chart_digit), 32'd1);
    chk({tag, "_label"}, 32'(bus_if.label_on), 32'd1);
    chk({tag, "_start"}, 32'(bus_if.chart_start), 32'd0);
    chk({tag, "_locked"}, 32'(bus_if.chart_locked), 32'd0);
  endtask

  int   toggles;
  int   starts;
  int   first_toggle;
  int   start_cycle;
  int   lock_cycle;
  int   prev_toggle;
  int   bad_gap;
  logic label_prev;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus_if.frame_tick  = 1'b0;
    bus_if.btn_next    = 1'b1;
    bus_if.btn_prev    = 1'b0;
    bus_if.btn_confirm = 1'b0;
    bus_if.game_done   = 1'b0;
    #22;
    chk_reset_outputs("reset");

    // btn_next held through reset release must not step the digit.
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_next_digit", 32'(bus_if.chart_digit), 32'd1);
    end
    bus_if.btn_next = 1'b0;
    tick();

    press(0, 4'd2, "next_1to2");
    press(0, 4'd3, "next_2to3");
`ifdef CHART_SEL_WRAP_EN
    press(0, 4'd1, "next_top_wrap");
    press(1, 4'd3, "prev_first_wrap");
    press(1, 4'd2, "prev_3to2");
`else
    press(0, 4'd3, "next_top_sat");
    press(1, 4'd2, "prev_3to2");
    press(1, 4'd1, "prev_2to1");
    press(1, 4'd1, "prev_first_sat");
    press(0, 4'd2, "next_1to2b");
`endif

    // Simultaneous next+prev is ignored.
    bus_if.btn_next = 1'b1;
    bus_if.btn_prev = 1'b1;
    tick();
    chk("next_prev_same", 32'(bus_if.chart_digit), 32'd2);
    bus_if.btn_next = 1'b0;
    bus_if.btn_prev = 1'b0;
    tick();
    chk("browse_label", 32'(bus_if.label_on), 32'd1);

    // Confirm beats next; label drops immediately on entry.
    bus_if.btn_confirm = 1'b1;
    bus_if.btn_next    = 1'b1;
    tick();
    chk("confirm_digit", 32'(bus_if.chart_digit), 32'd2);
    chk("confirm_label_off", 32'(bus_if.label_on), 32'd0);
    chk("confirm_no_start", 32'(bus_if.chart_start), 32'd0);

    // Blink phase: ticks every 4 cycles, buttons chattering throughout.
    toggles = 0; starts = 0; first_toggle = -1; start_cycle = -1; lock_cycle = -1;
    prev_toggle = -1; bad_gap = 0;
    label_prev = bus_if.label_on;
    for (int i = 0; i < 200; i++) begin
      bus_if.frame_tick  = (i % 4 == 0);
      bus_if.btn_next    = (i % 6 < 3);
      bus_if.btn_prev    = (i % 10 < 5);
      bus_if.btn_confirm = (i % 14 < 7);
      tick();
      if (bus_if.label_on !== label_prev) begin
        toggles++;
        if (first_toggle < 0) first_toggle = i;
        if (prev_toggle >= 0 && (i - prev_toggle) != 32) bad_gap++;
        prev_toggle = i;
      end
      label_prev = bus_if.label_on;
      if (bus_if.chart_start === 1'b1) begin
        starts++;
        start_cycle = i;
      end
      if (bus_if.chart_locked === 1'b1 && lock_cycle < 0) lock_cycle = i;
    end
    bus_if.frame_tick  = 1'b0;
    bus_if.btn_next    = 1'b0;
    bus_if.btn_prev    = 1'b0;
    bus_if.btn_confirm = 1'b0;
    chk("blink_toggles", 32'(toggles), 32'd5);
    chk("blink_first_toggle", 32'(first_toggle), 32'd28);
    chk("blink_period_errs", 32'(bad_gap), 32'd0);
    chk("start_count", 32'(starts), 32'd1);
    chk("start_cycle", 32'(start_cycle), 32'd156);
    chk("lock_with_start", 32'(lock_cycle), 32'd156);
    chk("locked_label", 32'(bus_if.label_on), 32'd1);
    chk("locked_digit", 32'(bus_if.chart_digit), 32'd2);
    chk("locked_flag", 32'(bus_if.chart_locked), 32'd1);

    press(0, 4'd2, "locked_next_ignored");
    press(0, 4'd2, "locked_next_ignored2");
    chk("locked_still", 32'(bus_if.chart_locked), 32'd1);

    // Next held across LOCKED->BROWSE must not act.
    bus_if.btn_next = 1'b1;
    tick();
    bus_if.game_done = 1'b1;
    tick();
    bus_if.game_done = 1'b0;
    chk("done_unlock", 32'(bus_if.chart_locked), 32'd0);
    chk("done_digit", 32'(bus_if.chart_digit), 32'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("held_across_done", 32'(bus_if.chart_digit), 32'd2);
    bus_if.btn_next = 1'b0;
    tick();

    // game_done in BROWSE is ignored.
    bus_if.game_done = 1'b1;
    tick();
    bus_if.game_done = 1'b0;
    tick();
    chk("done_browse_locked", 32'(bus_if.chart_locked), 32'd0);
    chk("done_browse_start", 32'(bus_if.chart_start), 32'd0);
    press(0, 4'd3, "browse_after_done");

    // Reset asserted mid-CONFIRM clears everything without a clock edge.
    bus_if.btn_confirm = 1'b1;
    tick();
    bus_if.btn_confirm = 1'b0;
    chk("confirm2_label_off", 32'(bus_if.label_on), 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus_if.frame_tick = (i % 4 == 0);
      tick();
    end
    bus_if.frame_tick = 1'b0;
    chk("confirm2_still_off", 32'(bus_if.label_on), 32'd0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.chart_start === 1'b1) starts++;
    end
    resetn = 1'b1;
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      bus_if.frame_tick = (i % 4 == 0);
      tick();
      if (bus_if.chart_start === 1'b1) starts++;
    end
    bus_if.frame_tick = 1'b0;
    chk("post_reset_no_start", 32'(starts), 32'd0);
    chk_reset_outputs("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chart_select_ctrl.md
Name: chart_select_ctrl

Overview:
- Sequences the chart-selection screen. Owns the digit shown by the "CHART n" label overlay and the label's visibility.
- Steps the chart number on next/prev buttons and blinks the label on confirm. Then issues a one-cycle start pulse to the game core.
- Holds the selection locked until the game reports completion.
- Sits between the button front-end and the VGA overlay/game core. Frame-paced via frame_tick.

Parameters:
- FIRST_CHART, 1: lowest selectable chart digit.
- NUM_CHARTS, 3: number of selectable charts. FIRST_CHART+NUM_CHARTS-1 must be ≤ 9.
- BLINK_FRAMES, 8: frame_ticks per label on/off half-period during confirm.
- CONFIRM_BLINKS, 3: full off/on blink cycles before start.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse once per video frame
- btn_next  in  1  synchronised button level, active-high
- btn_prev  in  1  synchronised button level, active-high
- btn_confirm  in  1  synchronised button level, active-high
- game_done  in  1  one-cycle pulse: chart finished, return to selection
- chart_digit  out  4  digit for the label overlay (FIRST_CHART..FIRST_CHART+NUM_CHARTS-1)
- label_on  out  1  label visible (gates overlay_on)
- chart_start  out  1  one-cycle pulse: begin playing chart_digit
- chart_locked  out  1  high while a chart is being played

Behaviour:
- Reset values (all registered, all async-clear on resetn low, any time):
  - chart_digit=FIRST_CHART, label_on=1, chart_start=0, chart_locked=0.
  - State BROWSE. Frame and blink counters 0.
  - Button history registers reset to 1, so a button held through reset release produces no press.
- Press = rising edge of a button level (current=1, previous=0). At most one press per button per edge.
- States: BROWSE, CONFIRM, START, LOCKED.
- BROWSE:
  - Confirm press → CONFIRM next cycle. Confirm has priority over next/prev in the same cycle; digit unchanged.
  - Next and prev pressed in the same cycle → ignored.
  - Next press: chart_digit+1 on the next clock edge (1-cycle latency). At the top value, behaviour is per CHART_SEL_WRAP_EN.
  - Prev press: chart_digit−1 on the next clock edge. At FIRST_CHART, behaviour is per CHART_SEL_WRAP_EN.
  - label_on=1 throughout.
- CONFIRM:
  - All buttons ignored.
  - Entering CONFIRM clears the frame counter and the toggle counter, and drives label_on=0 (first toggle immediate).
  - Each frame_tick increments the frame counter. When it reaches BLINK_FRAMES: counter clears, label_on toggles, toggle counter increments.
  - After 2*CONFIRM_BLINKS−1 further toggles, label_on is 1 and the state moves to START on the same edge.
  - frame_tick coincident with state entry does not count.
- START: chart_start=1 for exactly one cycle, chart_locked=1 from this cycle, then → LOCKED.
- LOCKED:
  - chart_locked=1, label_on=1, buttons ignored.
  - game_done → BROWSE next cycle; chart_locked=0 and chart_digit is retained.
  - A button held across the LOCKED→BROWSE transition does not act; press detection continues updating history in all states.
- game_done is ignored outside LOCKED.
- Counter widths: sized by $clog2 of (BLINK_FRAMES+1) and (2*CONFIRM_BLINKS+1). All digit arithmetic is 4-bit, with no overflow possible given the parameter constraint.

Optional Feature:
- CHART_SEL_WRAP_EN defined: next at top value → FIRST_CHART; prev at FIRST_CHART → top value.
- Not defined: both saturate; the press is consumed with no change.

Decomposition:
- Shared package chart_pkg:
  - state enum (BROWSE/CONFIRM/START/LOCKED)
  - DIGIT_W=4
  - default FIRST_CHART/NUM_CHARTS constants, shared with the game core's chart ROM select
- One natural sub-module: btn_edge_detect, a per-button history register with async reset-to-1, outputting a one-cycle press pulse. Instantiated three times.

Test Plan:
- Reset with btn_next held high, release resetn, keep holding 10 cycles → chart_digit stays 1, no change.
- BROWSE: two next presses → digit 1→2→3, each visible 1 cycle after the edge. Third next → 3 (saturate) or 1 (CHART_SEL_WRAP_EN). Prev at 1 → 1 or 3 respectively.
- Next and prev rising in the same cycle → digit unchanged. Confirm and next in the same cycle → CONFIRM entered, digit unchanged.
- Confirm at digit 2, frame_tick every 4 cycles, BLINK_FRAMES=8, CONFIRM_BLINKS=3 → label_on toggles 6 times total, ending high, then exactly one chart_start pulse with chart_digit=2. chart_locked rises with it. Button presses during the blink are ignored.
- LOCKED: next presses are ignored. game_done pulse → BROWSE, chart_locked=0, digit still 2. game_done pulsed in BROWSE → no effect.
- resetn asserted mid-CONFIRM (label_on=0) → all outputs return to reset values asynchronously, with no chart_start emitted.
